// File: rtl/module_hamming_decoder_pkg.sv
// Shared Hamming(7,4) types, bit positions and syndrome helper.
// Word layout bit6..0 = {i3,i2,i1,c2,i0,c1,c0}.
package hamming_pkg;
  typedef logic [6:0] codeword_t;
  typedef logic [3:0] data_t;
  typedef logic [2:0] syndrome_t;

  localparam int STAGES = 2;
  localparam int POS_C0 = 0;
  localparam int POS_C1 = 1;
  localparam int POS_I0 = 2;
  localparam int POS_C2 = 3;
  localparam int POS_I1 = 4;
  localparam int POS_I2 = 5;
  localparam int POS_I3 = 6;

  typedef struct packed {
    data_t     data;
    syndrome_t syndrome;
    logic      err_corrected;
    logic [2:0] err_pos;
  } dec_rsp_t;

  // Nonzero result is the 1-based position of the flipped bit.
  function automatic syndrome_t calc_syndrome(codeword_t w);
    syndrome_t s;
    s[0] = w[POS_I3] ^ w[POS_I1] ^ w[POS_I0] ^ w[POS_C0];
    s[1] = w[POS_I3] ^ w[POS_I2] ^ w[POS_I0] ^ w[POS_C1];
    s[2] = w[POS_I3] ^ w[POS_I2] ^ w[POS_I1] ^ w[POS_C2];
    return s;
  endfunction

  function automatic data_t extract_data(codeword_t w);
    return {w[POS_I3], w[POS_I2], w[POS_I1], w[POS_I0]};
  endfunction
endpackage

// File: rtl/module_hamming_decoder_if.sv
// Decoder stream interface: codeword in, corrected bundle out, valid/ready on both sides.
interface module_hamming_decoder_if;
  import hamming_pkg::*;

  logic       in_valid;
  logic       in_ready;
  codeword_t  code_in;
  logic       out_valid;
  logic       out_ready;
  data_t      data_out;
  syndrome_t  syndrome;
  logic       err_corrected;
  logic [2:0] err_pos;

  modport slave (
    input  in_valid, code_in, out_ready,
    output in_ready, out_valid, data_out, syndrome, err_corrected, err_pos
  );

  modport master (
    output in_valid, code_in, out_ready,
    input  in_ready, out_valid, data_out, syndrome, err_corrected, err_pos
  );
endinterface

// File: rtl/module_hamming_decoder_correct.sv
// Combinational single-bit corrector: flips the bit named by the syndrome, extracts data.
module hamming_correct
  import hamming_pkg::*;
(
  input  codeword_t  code,
  input  syndrome_t  syn,
  output data_t      data,
  output logic [2:0] err_pos
);
  codeword_t fixed;

  always_comb begin
    err_pos = '0;
    fixed   = code;
    if (syn != '0) begin
      err_pos = syn - 3'd1;
      fixed   = code ^ (codeword_t'(1) << err_pos);
    end
    data = extract_data(fixed);
  end
endmodule

// File: rtl/module_hamming_decoder.sv
// Hamming(7,4) receive decoder: S1 registers word+syndrome, S2 registers the corrected
// bundle; elastic valid/ready with a saturating corrected-word counter.
module module_hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  module_hamming_decoder_if.slave bus,
  input  logic                  clr_count,
  output logic [CNT_W-1:0]      err_count
);
  // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied
  logic [STAGES:1] vld_pipe;
  codeword_t       s1_code;
  syndrome_t       s1_syn;
  dec_rsp_t        s2_q;
  dec_rsp_t        s2_d;
  data_t           corr_data;
  logic [2:0]      corr_pos;
  logic            in_fire;
  logic            s2_load;
  logic            out_fire;

  assign s2_load      = vld_pipe[1] && (!vld_pipe[2] || bus.out_ready);
  assign bus.in_ready = !vld_pipe[1] || s2_load;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = vld_pipe[2] && bus.out_ready;

  hamming_correct u_correct (
    .code    (s1_code),
    .syn     (s1_syn),
    .data    (corr_data),
    .err_pos (corr_pos)
  );

  assign s2_d = '{data: corr_data, syndrome: s1_syn,
                  err_corrected: (s1_syn != '0), err_pos: corr_pos};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s2_q     <= '0;
    end else begin
      if (in_fire) begin
        s1_code <= bus.code_in;
        s1_syn  <= calc_syndrome(bus.code_in);
      end
      if (s2_load) s2_q <= s2_d;
      vld_pipe[1] <= in_fire || (vld_pipe[1] && !s2_load);
      vld_pipe[2] <= s2_load || (vld_pipe[2] && !bus.out_ready);
    end
  end

  // Clear wins over a same-cycle increment; counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_count)
      err_count <= '0;
    else if (out_fire && s2_q.err_corrected && (err_count != '1))
      err_count <= err_count + CNT_W'(1);
  end

  assign bus.out_valid     = vld_pipe[2];
  assign bus.data_out      = s2_q.data;
  assign bus.syndrome      = s2_q.syndrome;
  assign bus.err_corrected = s2_q.err_corrected;
  assign bus.err_pos       = s2_q.err_pos;
endmodule

// File: tb/tb_module_hamming_decoder.sv
// Scoreboard bench for the Hamming(7,4) decoder: driver pushes expected bundles on
// input handshake, a negedge monitor pops/compares on output and tracks err_count.
module tb_module_hamming_decoder;
  import hamming_pkg::*;

  typedef struct {
    data_t      d;
    syndrome_t  s;
    logic       e;
    logic [2:0] p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_count = 1'b0;
  logic [1:0] err_count;
  logic [1:0] model_cnt = '0;
  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         n_acc = 0;
  bit         rnd_done = 0;

  module_hamming_decoder_if bus();

  module_hamming_decoder #(.CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_count (clr_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic codeword_t encode(data_t d);
    logic c0, c1, c2;
    c0 = d[0] ^ d[1] ^ d[3];
    c1 = d[0] ^ d[2] ^ d[3];
    c2 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], c2, d[0], c1, c0};
  endfunction

  task automatic send(input codeword_t w, input exp_t e);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.code_in  = w;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(e);
        n_acc++;
        ok = 1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.code_in  = '0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout word=%h", w);
    end
  endtask

  // flip 0..6 corrupts that bit; 7 sends the clean word
  task automatic send_enc(input data_t d, input int flip);
    codeword_t w;
    exp_t e;
    w = encode(d);
    e = '{d: d, s: 3'd0, e: 1'b0, p: 3'd0};
    if (flip < 7) begin
      w[flip] = ~w[flip];
      e.s = 3'(flip + 1);
      e.e = 1'b1;
      e.p = 3'(flip);
    end
    send(w, e);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: outputs and counter are sampled mid-cycle, model advanced for the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      model_cnt = '0;
    end else begin
      checks++;
      if (err_count !== model_cnt) begin
        errors++;
        $display("FAIL err_count actual=%0d required=%0d", err_count, model_cnt);
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out data=%b syn=%0d", bus.data_out, bus.syndrome);
        end else begin
          e = q[0];
          if (bus.data_out !== e.d || bus.syndrome !== e.s ||
              bus.err_corrected !== e.e || bus.err_pos !== e.p) begin
            errors++;
            $display("FAIL out_word actual d=%b s=%0d e=%b p=%0d required d=%b s=%0d e=%b p=%0d",
                     bus.data_out, bus.syndrome, bus.err_corrected, bus.err_pos,
                     e.d, e.s, e.e, e.p);
          end
          if (bus.out_ready === 1'b1) begin
            if (e.e && model_cnt != 2'd3) model_cnt = model_cnt + 2'd1;
            void'(q.pop_front());
          end
        end
      end
      if (clr_count) model_cnt = '0;
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.code_in   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_data_out", int'(bus.data_out), 0);
    check("rst_syndrome", int'(bus.syndrome), 0);
    check("rst_err_pos", int'(bus.err_pos), 0);
    @(posedge clk); #1;

    // clean 0x55 then its bit5 flip 0x75
    send(7'h55, '{d: 4'b1011, s: 3'd0, e: 1'b0, p: 3'd0});
    wait_drain();
    check("clean_count", int'(err_count), 0);
    send(7'h75, '{d: 4'b1011, s: 3'd6, e: 1'b1, p: 3'd5});
    send(7'h54, '{d: 4'b1011, s: 3'd1, e: 1'b1, p: 3'd0});
    send(7'h00, '{d: 4'b0000, s: 3'd0, e: 1'b0, p: 3'd0});
    send(7'h7f, '{d: 4'b1111, s: 3'd0, e: 1'b0, p: 3'd0});
    send(7'h3f, '{d: 4'b1111, s: 3'd7, e: 1'b1, p: 3'd6});
    wait_drain();

    // all 16 data values x all 7 single-bit flips plus clean
    for (int d = 0; d < 16; d++)
      for (int f = 0; f < 8; f++)
        send_enc(4'(d), f);
    wait_drain();

    // backpressure: out_ready low for 3 edges while streaming 4 words
    @(posedge clk); #1;
    n_acc = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        send_enc(4'h3, 7);
        send_enc(4'h9, 2);
        send_enc(4'hc, 7);
        send_enc(4'h6, 4);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", int'(bus.in_ready), 0);
        check("bp_accepted", n_acc, 2);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_total", n_acc, 4);

    // saturation with CNT_W=2, then clear against a concurrent corrected word
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    check("clr_count", int'(err_count), 0);
    for (int i = 0; i < 5; i++) send_enc(4'(i + 1), i);
    wait_drain();
    check("sat_count", int'(err_count), 3);
    bus.out_ready = 1'b0;
    send_enc(4'ha, 3);
    for (int k = 0; k < 10 && !bus.out_valid; k++) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    check("clr_vs_inc", int'(err_count), 0);
    wait_drain();

    // reset with both stages full
    send_enc(4'h5, 1);
    wait_drain();
    check("pre_rst_count", int'(err_count), 1);
    bus.out_ready = 1'b0;
    send_enc(4'h7, 0);
    send_enc(4'h8, 6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_count", int'(err_count), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(7'h55, '{d: 4'b1011, s: 3'd0, e: 1'b0, p: 3'd0});
    wait_drain();

    // random valid/ready/clear traffic
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
          end
          send_enc(4'($urandom_range(15)), int'($urandom_range(7)));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(3) != 0);
          clr_count     = ($urandom_range(63) == 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    clr_count = 1'b0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
